// File: rtl/ac_access_ctrl.sv
// ac_access_ctrl: shares one accumulator (AC) between two requesters.
//
// Requester 0 is the CPU control unit and requester 1 is the I/O/debug port.
// Each requester issues READ / WRITE / CLEAR commands over a valid/ready handshake.
// The controller sequences the AC strobes, returns read data, and pulses a
// completion flag for the requester that issued the command.
//
// Ports:
//   clk, rst_n                   clock (rising edge), synchronous active-low reset
//   reqN_valid/cmd/wdata         command from requester N (cmd: 00 RD, 01 WR, 10 CLR, 11 rsvd)
//   reqN_ready                   combinational accept, high only in IDLE for the winner
//   reqN_done                    one-cycle completion pulse for requester N
//   rdata                        last read result
//   done_err                     pulses with reqN_done when the command was reserved
//   ac_in1/ac_re/ac_we/ac_clear  drive the AC instance
//   ac_out1                      AC read data
//   busy                         high whenever the controller is not idle
//   grant_id                     id of the current or last granted requester
module ac_access_ctrl #(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned READ_LAT = 1,   // 1..3
   parameter int unsigned FAIR     = 1    // 1 round-robin, 0 fixed priority to requester 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [1:0]        req0_cmd,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   input  logic              req1_valid,
   input  logic [1:0]        req1_cmd,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] rdata,
   output logic              done_err,
   output logic [DATA_W-1:0] ac_in1,
   output logic              ac_re,
   output logic              ac_we,
   output logic              ac_clear,
   input  logic [DATA_W-1:0] ac_out1,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   localparam logic [1:0] CmdRead  = 2'b00;
   localparam logic [1:0] CmdWrite = 2'b01;
   localparam logic [1:0] CmdClear = 2'b10;
   localparam logic [1:0] CmdRsvd  = 2'b11;

   state_e            state_q;
   logic [1:0]        cmd_q;
   logic [DATA_W-1:0] wdata_q;
   logic              id_q;
   logic              last_q;
   logic [1:0]        cnt_q;
   logic              re_q;
   logic              we_q;
   logic              clr_q;
   logic [DATA_W-1:0] in1_q;
   logic              done0_q;
   logic              done1_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              grant_q;

   logic              win;
   logic              accept;
   logic [1:0]        sel_cmd;
   logic [DATA_W-1:0] sel_wdata;

   // Winner id. When only one requester is valid it wins in either mode; with
   // neither valid the value is don't-care because ready is gated by valid.
   always_comb begin
      win = ~req0_valid;
      if (FAIR != 0) begin
         if (req0_valid && req1_valid) begin
            win = ~last_q;
         end
      end
   end

   assign req0_ready = (state_q == StIdle) && req0_valid && !win;
   assign req1_ready = (state_q == StIdle) && req1_valid && win;
   assign accept     = req0_ready || req1_ready;
   assign sel_cmd    = req1_ready ? req1_cmd : req0_cmd;
   assign sel_wdata  = req1_ready ? req1_wdata : req0_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cmd_q   <= CmdRead;
         wdata_q <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;  // requester 0 wins the first tie
         cnt_q   <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         clr_q   <= 1'b0;
         in1_q   <= '0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         grant_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  cmd_q   <= sel_cmd;
                  wdata_q <= sel_wdata;
                  id_q    <= req1_ready;
                  grant_q <= req1_ready;
                  state_q <= StIssue;
                  // Strobes are registered, so they are raised here to be
                  // visible throughout the ISSUE cycle.
                  unique case (sel_cmd)
                     CmdWrite: begin
                        we_q  <= 1'b1;
                        in1_q <= sel_wdata;
                     end
                     CmdClear: clr_q <= 1'b1;
                     CmdRead:  re_q  <= 1'b1;
                     CmdRsvd:  ;
                  endcase
               end
            end
            StIssue: begin
               we_q  <= 1'b0;
               clr_q <= 1'b0;
               in1_q <= '0;
               cnt_q <= 2'(READ_LAT);
               if (cmd_q == CmdRead) begin
                  state_q <= StWait;
               end else begin
                  state_q <= StDone;
                  done0_q <= !id_q;
                  done1_q <= id_q;
                  err_q   <= (cmd_q == CmdRsvd);
               end
            end
            StWait: begin
               if (cnt_q == 2'd1) begin
                  rdata_q <= ac_out1;
                  re_q    <= 1'b0;
                  state_q <= StDone;
                  done0_q <= !id_q;
                  done1_q <= id_q;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            StDone: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               err_q   <= 1'b0;
               last_q  <= id_q;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req0_done = done0_q;
   assign req1_done = done1_q;
   assign done_err  = err_q;
   assign rdata     = rdata_q;
   assign ac_in1    = in1_q;
   assign ac_re     = re_q;
   assign ac_we     = we_q;
   assign ac_clear  = clr_q;
   assign busy      = (state_q != StIdle);
   assign grant_id  = grant_q;

endmodule

// File: tb/tb_ac_access_ctrl.sv
// Bench for ac_access_ctrl. Three instances run side by side:
//   dut0: READ_LAT=1, FAIR=1   dut1: READ_LAT=3, FAIR=1   dut2: READ_LAT=1, FAIR=0
// Each instance has its own requester inputs and its own AC register. A
// transaction-timeline model predicts every output on every cycle; directed
// sequences add hand-computed literal expectations.
module tb_ac_access_ctrl;

   localparam int N = 3;
   localparam logic [1:0] RD = 2'b00;
   localparam logic [1:0] WR = 2'b01;
   localparam logic [1:0] CL = 2'b10;
   localparam logic [1:0] RS = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       vld  [N][2];
   logic [1:0] cmd  [N][2];
   logic [9:0] wd   [N][2];
   logic       rdy  [N][2];
   logic       dn   [N][2];
   logic [9:0] rdata[N];
   logic [9:0] in1  [N];
   logic [9:0] out1 [N];
   logic       derr [N];
   logic       re   [N];
   logic       we   [N];
   logic       clr  [N];
   logic       busy [N];
   logic       gid  [N];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [9:0] acc_r = '0;

      ac_access_ctrl #(
         .DATA_W  (10),
         .READ_LAT((g == 1) ? 3 : 1),
         .FAIR    ((g == 2) ? 0 : 1)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req0_valid(vld[g][0]),
         .req0_cmd  (cmd[g][0]),
         .req0_wdata(wd[g][0]),
         .req0_ready(rdy[g][0]),
         .req0_done (dn[g][0]),
         .req1_valid(vld[g][1]),
         .req1_cmd  (cmd[g][1]),
         .req1_wdata(wd[g][1]),
         .req1_ready(rdy[g][1]),
         .req1_done (dn[g][1]),
         .rdata     (rdata[g]),
         .done_err  (derr[g]),
         .ac_in1    (in1[g]),
         .ac_re     (re[g]),
         .ac_we     (we[g]),
         .ac_clear  (clr[g]),
         .ac_out1   (out1[g]),
         .busy      (busy[g]),
         .grant_id  (gid[g])
      );

      // Simple AC: clear wins over write, read data always reflects contents.
      always @(posedge clk) begin
         if (clr[g]) acc_r <= '0;
         else if (we[g]) acc_r <= in1[g];
      end
      assign out1[g] = acc_r;
   end

   function automatic int rl_of(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   function automatic bit fair_of(input int k);
      return (k != 2);
   endfunction

   task automatic chk(input string nm, input int k, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d: got 0x%0h want 0x%0h", nm, k, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A command accepted at cycle T sits at phase p = cycle - T. Phase 1 carries
   // the write/clear strobe; a read holds re for phases 1..1+RL; done lands at
   // phase 2 (2+RL for reads).
   bit         m_busy [N] = '{default: 1'b0};
   int         m_ph   [N] = '{default: 0};
   int         m_d    [N] = '{default: 0};
   logic [1:0] m_cmd  [N] = '{default: 2'b00};
   logic [9:0] m_wd   [N] = '{default: 10'h0};
   logic [9:0] m_rdata[N] = '{default: 10'h0};
   logic [9:0] m_acc  [N] = '{default: 10'h0};
   bit         m_id   [N] = '{default: 1'b0};
   bit         m_last [N] = '{default: 1'b1};
   bit         m_grant[N] = '{default: 1'b0};

   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         int  er[2];
         int  w;
         int  p;
         bit  pwe, pcl, pre, pd;
         er[0] = 0;
         er[1] = 0;
         if (!m_busy[k]) begin
            if (vld[k][0] && vld[k][1]) w = fair_of(k) ? int'(!m_last[k]) : 0;
            else w = int'(vld[k][1]);
            er[w] = int'(vld[k][w]);
         end
         p   = m_ph[k];
         pwe = m_busy[k] && p == 1 && m_cmd[k] == WR;
         pcl = m_busy[k] && p == 1 && m_cmd[k] == CL;
         pre = m_busy[k] && m_cmd[k] == RD && p >= 1 && p <= 1 + rl_of(k);
         pd  = m_busy[k] && p == m_d[k];
         if (rst_n) begin
            chk("ready0", k, rdy[k][0], er[0]);
            chk("ready1", k, rdy[k][1], er[1]);
            chk("busy", k, busy[k], m_busy[k]);
            chk("ac_we", k, we[k], pwe);
            chk("ac_clear", k, clr[k], pcl);
            chk("ac_re", k, re[k], pre);
            chk("ac_in1", k, in1[k], pwe ? m_wd[k] : 10'h0);
            chk("done0", k, dn[k][0], pd && !m_id[k]);
            chk("done1", k, dn[k][1], pd && m_id[k]);
            chk("done_err", k, derr[k], pd && m_cmd[k] == RS);
            chk("rdata", k, rdata[k], m_rdata[k]);
            chk("grant_id", k, gid[k], m_grant[k]);
            chk("one_strobe", k, int'(re[k]) + int'(we[k]) + int'(clr[k]) <= 1, 1);
            chk("one_ready", k, int'(rdy[k][0]) + int'(rdy[k][1]) <= 1, 1);
            chk("one_done", k, int'(dn[k][0]) + int'(dn[k][1]) <= 1, 1);
            chk("ready_while_busy", k, (rdy[k][0] || rdy[k][1]) && busy[k], 0);
         end
         // advance the model to the next cycle
         if (!rst_n) begin
            m_busy[k]  = 1'b0;
            m_ph[k]    = 0;
            m_last[k]  = 1'b1;
            m_grant[k] = 1'b0;
            m_rdata[k] = '0;
         end else if (m_busy[k]) begin
            if (p == m_d[k]) begin
               m_busy[k] = 1'b0;
               m_last[k] = m_id[k];
            end else begin
               m_ph[k] = p + 1;
               if (m_ph[k] == m_d[k] && m_cmd[k] == RD) m_rdata[k] = m_acc[k];
            end
         end else if (er[0] != 0 || er[1] != 0) begin
            w          = er[1];
            m_busy[k]  = 1'b1;
            m_ph[k]    = 1;
            m_id[k]    = w[0];
            m_grant[k] = w[0];
            m_cmd[k]   = cmd[k][w];
            m_wd[k]    = wd[k][w];
            m_d[k]     = (cmd[k][w] == RD) ? 2 + rl_of(k) : 2;
            if (cmd[k][w] == WR) m_acc[k] = wd[k][w];
            if (cmd[k][w] == CL) m_acc[k] = '0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called #1 after a rising edge. Returns #1 after the accepting edge (T+1).
   task automatic send(input int k, input int r, input logic [1:0] c, input logic [9:0] w);
      bit got = 1'b0;
      vld[k][r] = 1'b1;
      cmd[k][r] = c;
      wd[k][r]  = w;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = rdy[k][r];
         @(posedge clk);
         #1;
      end
      vld[k][r] = 1'b0;
      chk("accept_timeout", k, got, 1);
   endtask

   task automatic wait_idle(input int k);
      bit idle = 1'b0;
      for (int i = 0; i < 20 && !idle; i++) begin
         @(negedge clk);
         idle = !busy[k];
         @(posedge clk);
         #1;
      end
      chk("idle_timeout", k, idle, 1);
   endtask

   // pat[i] is the expected id of the i-th grant.
   task automatic fair_run(input int k, input logic [3:0] pat);
      int n = 0;
      vld[k][0] = 1'b1;
      cmd[k][0] = WR;
      wd[k][0]  = 10'h001;
      vld[k][1] = 1'b1;
      cmd[k][1] = CL;
      wd[k][1]  = 10'h000;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge clk);
         if (rdy[k][0] || rdy[k][1]) begin
            chk("grant_seq", k, rdy[k][1], pat[n]);
            n++;
         end
         @(posedge clk);
         #1;
      end
      vld[k][0] = 1'b0;
      vld[k][1] = 1'b0;
      chk("grant_count", k, n, 4);
      wait_idle(k);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_n;
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int r = 0; r < 2; r++) begin
            vld[k][r] = 1'b0;
            cmd[k][r] = 2'b00;
            wd[k][r]  = '0;
         end
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk("rst_busy", k, busy[k], 0);
         chk("rst_rdata", k, rdata[k], 0);
         chk("rst_grant", k, gid[k], 0);
         chk("rst_strobes", k, re[k] || we[k] || clr[k], 0);
      end
      @(posedge clk);
      #1;

      // WRITE 155 from req0 on dut0
      send(0, 0, WR, 10'h155);
      @(negedge clk);
      chk("wr_we", 0, we[0], 1);
      chk("wr_in1", 0, in1[0], 10'h155);
      chk("wr_no_re_clr", 0, re[0] || clr[0], 0);
      @(negedge clk);
      chk("wr_done", 0, dn[0][0], 1);
      @(posedge clk);
      #1;

      // READ from req1 on dut0 (READ_LAT=1): re at T+1..T+2, done at T+3
      send(0, 1, RD, 10'h000);
      @(negedge clk);
      chk("rd1_re_t1", 0, re[0], 1);
      @(negedge clk);
      chk("rd1_re_t2", 0, re[0], 1);
      @(negedge clk);
      chk("rd1_done", 0, dn[0][1], 1);
      chk("rd1_rdata", 0, rdata[0], 10'h155);
      chk("rd1_re_off", 0, re[0], 0);
      @(posedge clk);
      #1;

      // READ on dut1 (READ_LAT=3): done at T+5
      send(1, 0, WR, 10'h155);
      wait_idle(1);
      send(1, 1, RD, 10'h000);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) begin
            chk("rd3_re", 1, re[1], 1);
            chk("rd3_no_done", 1, dn[1][1], 0);
         end else begin
            chk("rd3_done", 1, dn[1][1], 1);
            chk("rd3_rdata", 1, rdata[1], 10'h155);
         end
      end
      @(posedge clk);
      #1;

      // arbitration with both requesters valid continuously
      fair_run(0, 4'b1010);
      fair_run(2, 4'b0000);

      // reserved command: no strobe, done+err at T+2, rdata untouched
      send(0, 0, RS, 10'h3ff);
      @(negedge clk);
      chk("rsv_no_strobe", 0, re[0] || we[0] || clr[0], 0);
      @(negedge clk);
      chk("rsv_done", 0, dn[0][0], 1);
      chk("rsv_err", 0, derr[0], 1);
      chk("rsv_rdata", 0, rdata[0], 10'h155);
      @(posedge clk);
      #1;

      // reset during the WAIT of a READ_LAT=3 read on dut1
      send(1, 1, RD, 10'h000);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstw_done", 1, dn[1][1], 0);
         chk("rstw_busy", 1, busy[1], 0);
         chk("rstw_rdata", 1, rdata[1], 0);
         chk("rstw_strobes", 1, re[1] || we[1] || clr[1], 0);
      end
      @(posedge clk);
      #1;
      // the aborted read must not have cleared the AC
      send(1, 1, RD, 10'h000);
      repeat (4) @(negedge clk);
      @(negedge clk);
      chk("rstw_ac_kept", 1, rdata[1], 10'h155);
      @(posedge clk);
      #1;

      // random traffic with valid drops; model and invariants checked each cycle
      acc_n = 0;
      for (int c = 0; c < 20000 && acc_n < 1000; c++) begin
         bit a[N][2];
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            for (int r = 0; r < 2; r++) a[k][r] = vld[k][r] && rdy[k][r];
         end
         acc_n += int'(a[0][0]) + int'(a[0][1]);
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            for (int r = 0; r < 2; r++) begin
               if (a[k][r] || !vld[k][r]) begin
                  if ($urandom_range(1, 0) == 1) begin
                     vld[k][r] = 1'b1;
                     cmd[k][r] = 2'($urandom_range(3, 0));
                     wd[k][r]  = 10'($urandom);
                  end else begin
                     vld[k][r] = 1'b0;
                  end
               end else if ($urandom_range(7, 0) == 0) begin
                  vld[k][r] = 1'b0;
               end
            end
         end
      end
      chk("random_progress", 0, acc_n >= 1000, 1);
      for (int k = 0; k < N; k++) begin
         vld[k][0] = 1'b0;
         vld[k][1] = 1'b0;
      end
      for (int k = 0; k < N; k++) wait_idle(k);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
